// File: rtl/jt6295_decim_if.sv
// Stream bundle for the 4:1 decimator: 4x-rate input strobes/data in,
// decimated sample and its update pulse out.
interface jt6295_decim_if #(
  parameter int IW = 14,
  parameter int OW = 14
);
  logic                 cen;
  logic                 cen4;
  logic signed [IW-1:0] sound_in;
  logic signed [OW-1:0] sound_out;
  logic                 sample;

  modport master (
    output cen,
    output cen4,
    output sound_in,
    input  sound_out,
    input  sample
  );

  modport slave (
    input  cen,
    input  cen4,
    input  sound_in,
    output sound_out,
    output sample
  );
endinterface

// File: rtl/jt6295_decim.sv
// 4:1 decimator built as a second-order CIC (differential delay 1).
// Integrators run on every cen4 sample; the comb pair runs once per group
// of four, one clock after the phase-3 sample. Output is rounded by the
// DC gain of 16 and saturated (or sign-extended) to OW bits, landing two
// clocks after the phase-3 sample edge.
module jt6295_decim #(
  parameter int IW = 14,
  parameter int OW = 14
) (
  input logic           clk,
  input logic           rst,
  jt6295_decim_if.slave io_bus
);

  // Integrator/comb width: the two integrators may wrap freely because the
  // combs undo the growth modulo 2^W, and the true filter result fits in W.
  localparam int W  = IW + 4;
  localparam int CW = (OW > W) ? OW + 1 : W + 1;

  localparam logic signed [CW-1:0] MAXV = CW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [CW-1:0] MINV = CW'(-(64'sd1 <<< (OW - 1)));

  logic [1:0]          r_phase;
  logic signed [W-1:0] r_i1;
  logic signed [W-1:0] r_i2;
  logic signed [W-1:0] r_i2d;
  logic signed [W-1:0] r_c1d;
  logic signed [W-1:0] r_c2;
  logic                r_dec;
  logic                r_comb;
  logic signed [OW-1:0] r_sound;
  logic                r_sample;

  logic signed [W-1:0]  w_x;
  logic signed [W-1:0]  w_i1;
  logic signed [W-1:0]  w_c1;
  logic signed [W-1:0]  w_c2;
  logic                 w_last;
  logic signed [W:0]    w_round;
  logic signed [W:0]    w_shift;
  logic signed [CW-1:0] w_y;
  logic signed [OW-1:0] w_sat;

  assign w_x  = {{(W - IW){io_bus.sound_in[IW-1]}}, io_bus.sound_in};
  assign w_i1 = r_i1 + w_x;

  // A cen coincident with cen4 forces phase 0, so a phase-3 sample can only
  // close a group when cen is low.
  assign w_last = io_bus.cen4 && !io_bus.cen && (r_phase == 2'd3);

  assign w_c1 = r_i2 - r_i2d;
  assign w_c2 = w_c1 - r_c1d;

  assign w_round = {r_c2[W-1], r_c2} + (W + 1)'(8);
  assign w_shift = w_round >>> 4;
  assign w_y     = CW'(w_shift);

  // Clamp the rounded comb result into the output range.
  always_comb begin
    w_sat = w_y[OW-1:0];
    if (w_y > MAXV) begin
      w_sat = MAXV[OW-1:0];
    end else if (w_y < MINV) begin
      w_sat = MINV[OW-1:0];
    end
  end

  // Integrators and phase tracking at the 4x rate; flag the group end.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase <= 2'd0;
      r_i1    <= '0;
      r_i2    <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_dec <= w_last;
      if (io_bus.cen4) begin
        r_i1    <= w_i1;
        r_i2    <= r_i2 + w_i1;
        r_phase <= io_bus.cen ? 2'd1 : r_phase + 2'd1;
      end
    end
  end

  // Comb pair at the decimated rate, fed by I2 as it stood after phase 3.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_i2d  <= '0;
      r_c1d  <= '0;
      r_c2   <= '0;
      r_comb <= 1'b0;
    end else begin
      r_comb <= r_dec;
      if (r_dec) begin
        r_i2d <= r_i2;
        r_c1d <= w_c1;
        r_c2  <= w_c2;
      end
    end
  end

  // Registered output stage: hold the value, pulse once per new sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sound  <= '0;
      r_sample <= 1'b0;
    end else begin
      r_sample <= r_comb;
      if (r_comb) begin
        r_sound <= w_sat;
      end
    end
  end

  assign io_bus.sound_out = r_sound;
  assign io_bus.sample    = r_sample;

endmodule

// File: tb/tb_jt6295_decim.sv
// Bench for jt6295_decim: two instances (OW=14 and OW=12) share one input
// stream. A reference model works on unbounded double running sums taken at
// the decimation instants, reduced to the filter width only at the end.
module tb_jt6295_decim;

  logic clk = 1'b0;
  logic rst;
  logic cen;
  logic cen4;
  logic signed [13:0] din;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  int gotA[$];
  int gotB[$];
  int gotC[$];
  int expA[$];
  int expB[$];
  int expC[$];

  longint s1, s2, pS2, pC1;
  int mPhase;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  jt6295_decim_if #(.IW(14), .OW(14)) busA ();
  jt6295_decim_if #(.IW(14), .OW(12)) busB ();

  assign busA.cen      = cen;
  assign busA.cen4     = cen4;
  assign busA.sound_in = din;
  assign busB.cen      = cen;
  assign busB.cen4     = cen4;
  assign busB.sound_in = din;

  jt6295_decim #(.IW(14), .OW(14)) dutA (.clk(clk), .rst(rst), .io_bus(busA));
  jt6295_decim #(.IW(14), .OW(12)) dutB (.clk(clk), .rst(rst), .io_bus(busB));

  // Record every output pulse with its value and the cycle it was seen.
  always @(negedge clk) begin
    if (rst === 1'b1 && busA.sample === 1'b1) begin
      gotA.push_back(int'(busA.sound_out));
      gotC.push_back(cyc);
    end
    if (rst === 1'b1 && busB.sample === 1'b1) begin
      gotB.push_back(int'(busB.sound_out));
    end
  end

  function automatic int sat(input int y, input int ow);
    int mx;
    mx = (1 << (ow - 1)) - 1;
    if (y > mx) return mx;
    if (y < -mx - 1) return -mx - 1;
    return y;
  endfunction

  function automatic void modelReset();
    s1 = 0; s2 = 0; pS2 = 0; pC1 = 0; mPhase = 0;
    gotA.delete(); gotB.delete(); gotC.delete();
    expA.delete(); expB.delete(); expC.delete();
  endfunction

  // One 4x-rate sample: running sums, phase rule, and at a group end the
  // second difference of the double sum between decimation instants.
  function automatic void modelStep(input int x, input bit c);
    int ph;
    longint c1, c2, w;
    int y;
    ph = c ? 0 : mPhase;
    s1 = s1 + x;
    s2 = s2 + s1;
    if (ph == 3) begin
      c1 = s2 - pS2;
      pS2 = s2;
      c2 = c1 - pC1;
      pC1 = c1;
      w = (c2 <<< 46) >>> 46;
      y = int'((w + 64'sd8) >>> 4);
      expA.push_back(sat(y, 14));
      expB.push_back(sat(y, 12));
      expC.push_back(cyc + 3);
    end
    mPhase = (ph + 1) % 4;
  endfunction

  task automatic driveSample(input int x, input bit c, input int gap, input bit gapCen);
    int xv;
    xv = x;
    cen4 = 1'b1;
    cen = c;
    din = xv[13:0];
    modelStep(x, c);
    @(negedge clk);
    cen4 = 1'b0;
    cen = 1'b0;
    for (int g = 0; g < gap; g++) begin
      cen = gapCen ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    cen = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    cen = 1'b0;
    cen4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    int lastCyc;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cen4 = ~cen4;
      cen = 1'b1;
      din = 14'($urandom);
      @(negedge clk);
      vectors++;
      if (busA.sound_out !== 14'sd0 || busA.sample !== 1'b0 ||
          busB.sound_out !== 12'sd0 || busB.sample !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold[%0d]: got out=%0d/%0d sample=%b/%b, want 0/0 sample=0/0",
                 i, busA.sound_out, busB.sound_out, busA.sample, busB.sample);
      end
    end
    cen4 = 1'b0;
    cen = 1'b0;
    rst = 1'b1;
    modelReset();
    lastCyc = 0;
    for (int k = 0; k < 4; k++) begin
      lastCyc = cyc;
      driveSample(int'($urandom_range(0, 16383)) - 8192, k == 0, 0, 1'b0);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (gotA.size() != 1 || gotB.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL reset_first_count: got %0d/%0d pulses, want 1", gotA.size(), gotB.size());
    end
    vectors++;
    if (gotA.size() < 1 || gotB.size() < 1 || gotC[0] !== lastCyc + 3 ||
        gotA[0] !== expA[0] || gotB[0] !== expB[0]) begin
      miscompares++;
      $display("[TB] FAIL reset_first_pulse: got %0d/%0d @%0d, want %0d/%0d @%0d",
               gotA.size() ? gotA[0] : 0, gotB.size() ? gotB[0] : 0,
               gotC.size() ? gotC[0] : -1, expA[0], expB[0], lastCyc + 3);
    end
  endtask

  task automatic test_dc();
    doReset();
    for (int g = 0; g < 12; g++)
      for (int k = 0; k < 4; k++)
        driveSample(1000, k == 0, 0, 1'b0);
    repeat (6) @(negedge clk);
    vectors++;
    if (gotA.size() != 12 || gotB.size() != 12 || expA.size() != 12) begin
      miscompares++;
      $display("[TB] FAIL dc_count: got %0d/%0d pulses, want 12", gotA.size(), gotB.size());
    end
    for (int i = 0; i < expA.size() && i < gotA.size() && i < gotB.size(); i++) begin
      vectors++;
      if (gotA[i] !== expA[i] || gotB[i] !== expB[i] || gotC[i] !== expC[i]) begin
        miscompares++;
        $display("[TB] FAIL dc[%0d]: got %0d/%0d @%0d, want %0d/%0d @%0d",
                 i, gotA[i], gotB[i], gotC[i], expA[i], expB[i], expC[i]);
      end
    end
    vectors++;
    if (gotA.size() < 12 || gotA[0] !== (1000 * (4 + 3 + 2 + 1) + 8) / 16 ||
        gotA[11] !== 1000 || gotB[11] !== 1000) begin
      miscompares++;
      $display("[TB] FAIL dc_levels: got first=%0d last=%0d, want first=625 last=1000",
               gotA.size() ? gotA[0] : 0, gotA.size() >= 12 ? gotA[11] : 0);
    end
  endtask

  task automatic test_impulse();
    int e0[4];
    int e1[4];
    e0 = '{16, 12, 8, 4};
    e1 = '{0, 4, 8, 12};
    for (int p = 0; p < 4; p++) begin
      doReset();
      for (int g = 0; g < 3; g++)
        for (int k = 0; k < 4; k++)
          driveSample((g == 0 && k == p) ? 64 : 0, k == 0, 0, 1'b0);
      repeat (6) @(negedge clk);
      vectors++;
      if (gotA.size() != 3 || gotB.size() != 3) begin
        miscompares++;
        $display("[TB] FAIL impulse%0d_count: got %0d/%0d pulses, want 3", p, gotA.size(), gotB.size());
      end
      for (int i = 0; i < expA.size() && i < gotA.size() && i < gotB.size(); i++) begin
        vectors++;
        if (gotA[i] !== expA[i] || gotB[i] !== expB[i] || gotC[i] !== expC[i]) begin
          miscompares++;
          $display("[TB] FAIL impulse%0d[%0d]: got %0d/%0d @%0d, want %0d/%0d @%0d",
                   p, i, gotA[i], gotB[i], gotC[i], expA[i], expB[i], expC[i]);
        end
      end
      vectors++;
      if (gotA.size() < 2 || gotA[0] !== e0[p] || gotA[1] !== e1[p]) begin
        miscompares++;
        $display("[TB] FAIL impulse%0d_taps: got %0d,%0d want %0d,%0d", p,
                 gotA.size() > 0 ? gotA[0] : 0, gotA.size() > 1 ? gotA[1] : 0, e0[p], e1[p]);
      end
    end
  endtask

  task automatic test_fullscale();
    int n;
    doReset();
    for (int g = 0; g < 10000; g++)
      for (int k = 0; k < 4; k++)
        driveSample(-8192, k == 0, 0, 1'b0);
    for (int g = 0; g < 16; g++)
      for (int k = 0; k < 4; k++)
        driveSample(8191, k == 0, 0, 1'b0);
    repeat (6) @(negedge clk);
    n = gotA.size();
    vectors++;
    if (n != 10016 || gotB.size() != 10016) begin
      miscompares++;
      $display("[TB] FAIL full_count: got %0d/%0d pulses, want 10016", n, gotB.size());
    end
    for (int i = 0; i < expA.size() && i < gotA.size() && i < gotB.size(); i++) begin
      vectors++;
      if (gotA[i] !== expA[i] || gotB[i] !== expB[i] || gotC[i] !== expC[i]) begin
        miscompares++;
        $display("[TB] FAIL full[%0d]: got %0d/%0d @%0d, want %0d/%0d @%0d",
                 i, gotA[i], gotB[i], gotC[i], expA[i], expB[i], expC[i]);
      end
    end
    vectors++;
    if (n < 10016 || gotA[9999] !== -8192 || gotB[9999] !== -2048) begin
      miscompares++;
      $display("[TB] FAIL full_neg: got %0d/%0d, want -8192/-2048",
               n >= 10016 ? gotA[9999] : 0, n >= 10016 ? gotB[9999] : 0);
    end
    vectors++;
    if (n < 10016 || gotA[n-1] !== 8191 || gotB[n-1] !== 2047) begin
      miscompares++;
      $display("[TB] FAIL full_pos: got %0d/%0d, want 8191/2047",
               n > 0 ? gotA[n-1] : 0, (n > 0 && gotB.size() >= n) ? gotB[n-1] : 0);
    end
  endtask

  task automatic test_resync();
    int rsCyc;
    doReset();
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 4; k++)
        driveSample(1000, k == 0, 0, 1'b0);
    driveSample(1000, 1'b1, 0, 1'b0);
    driveSample(1000, 1'b0, 0, 1'b0);
    rsCyc = cyc;
    driveSample(1000, 1'b1, 0, 1'b0);
    for (int k = 1; k < 4; k++) driveSample(1000, 1'b0, 0, 1'b0);
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++)
        driveSample(1000, k == 0, 0, 1'b0);
    repeat (6) @(negedge clk);
    vectors++;
    if (gotA.size() != 8 || gotB.size() != 8) begin
      miscompares++;
      $display("[TB] FAIL resync_count: got %0d/%0d pulses, want 8", gotA.size(), gotB.size());
    end
    for (int i = 0; i < expA.size() && i < gotA.size() && i < gotB.size(); i++) begin
      vectors++;
      if (gotA[i] !== expA[i] || gotB[i] !== expB[i] || gotC[i] !== expC[i]) begin
        miscompares++;
        $display("[TB] FAIL resync[%0d]: got %0d/%0d @%0d, want %0d/%0d @%0d",
                 i, gotA[i], gotB[i], gotC[i], expA[i], expB[i], expC[i]);
      end
    end
    vectors++;
    if (gotC.size() < 4 || gotC[3] !== rsCyc + 6) begin
      miscompares++;
      $display("[TB] FAIL resync_timing: got pulse @%0d, want @%0d",
               gotC.size() > 3 ? gotC[3] : -1, rsCyc + 6);
    end
    vectors++;
    if (gotA.size() < 8 || gotA[5] !== 1000 || gotA[7] !== 1000) begin
      miscompares++;
      $display("[TB] FAIL resync_settle: got %0d,%0d want 1000,1000",
               gotA.size() > 5 ? gotA[5] : 0, gotA.size() > 7 ? gotA[7] : 0);
    end
  endtask

  task automatic test_gapped();
    int data[32];
    int runA[$];
    for (int i = 0; i < 32; i++) data[i] = int'($urandom_range(0, 16383)) - 8192;
    for (int run = 0; run < 2; run++) begin
      doReset();
      for (int i = 0; i < 32; i++)
        driveSample(data[i], (i % 4) == 0, run ? 6 : 0, run == 1);
      repeat (6) @(negedge clk);
      vectors++;
      if (gotA.size() != 8 || gotB.size() != 8) begin
        miscompares++;
        $display("[TB] FAIL gap%0d_count: got %0d/%0d pulses, want 8", run, gotA.size(), gotB.size());
      end
      for (int i = 0; i < expA.size() && i < gotA.size() && i < gotB.size(); i++) begin
        vectors++;
        if (gotA[i] !== expA[i] || gotB[i] !== expB[i] || gotC[i] !== expC[i]) begin
          miscompares++;
          $display("[TB] FAIL gap%0d[%0d]: got %0d/%0d @%0d, want %0d/%0d @%0d",
                   run, i, gotA[i], gotB[i], gotC[i], expA[i], expB[i], expC[i]);
        end
      end
      if (run == 0) runA = gotA;
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (i >= runA.size() || i >= gotA.size() || runA[i] !== gotA[i]) begin
        miscompares++;
        $display("[TB] FAIL gap_same[%0d]: got %0d, want %0d", i,
                 i < gotA.size() ? gotA[i] : 0, i < runA.size() ? runA[i] : 0);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    cen = 1'b0;
    cen4 = 1'b0;
    din = '0;
    modelReset();
    repeat (2) @(negedge clk);
    test_reset();
    test_dc();
    test_impulse();
    test_fullscale();
    test_resync();
    test_gapped();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
